// File: rtl/staff_fb_pkg.sv
// Shared geometry and pixel constants for the 320x180 staff framebuffer.
// The pixel writer and the scan-out reader both import this package.
package staff_fb_pkg;

    localparam int FB_WIDTH     = 320;
    localparam int FB_HEIGHT    = 180;
    localparam int STAFF_TOP    = 75;
    localparam int STAFF_HEIGHT = 35;
    localparam int CELL_WIDTH   = 5;

    localparam logic [7:0]  PIX_WHITE      = 8'hFF;
    localparam logic [7:0]  PIX_STAFF_LINE = 8'h94;
    localparam logic [15:0] FB_LAST_ADDR   = 16'(FB_WIDTH * FB_HEIGHT - 1);

    typedef struct packed {
        logic valid;
        logic in_range;
        logic cursor;
        logic hsync;
        logic vsync;
        logic active_draw;
    } pix_flags_t;

    // fy*320 + fx as two shifts and adds, so no multiplier is inferred.
    function automatic logic [15:0] fb_addr_of(input logic [15:0] fx, input logic [15:0] fy);
        return (fy << 8) + (fy << 6) + fx;
    endfunction

endpackage

// File: rtl/pipeline_delay.sv
// Fixed-length shift register for strobes and per-pixel flags.
// All stages clear asynchronously so a reset blanks everything in flight.
module pipeline_delay #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/staff_frame_reader.sv
// Scan-out reader: maps 1280x720 screen coordinates onto the 320x180 staff
// framebuffer, hides the RAM read latency and overlays the playhead cursor.
module staff_frame_reader
    import staff_fb_pkg::*;
#(
    parameter int   SCALE_LOG2   = 2,
    parameter int   READ_LATENCY = 2,
    parameter logic CURSOR_EN    = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        active_draw_in,
    input  logic        new_frame_in,
    input  logic [5:0]  current_staff_cell_in,
    input  logic [15:0] fb_data_in,
    output logic [15:0] fb_addr_out,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_draw_out,
    output logic        frame_read_done_out
);

    logic [10:0] fx;
    logic [9:0]  fy;
    logic        in_range;
    logic [15:0] addr_next;
    logic [5:0]  cell_q;
    logic [10:0] cell_x0;
    logic        cursor;
    logic        last_hit;
    logic        done_sticky_q;
    pix_flags_t  flags_in;
    pix_flags_t  flags_dly;
    logic [7:0]  pix_data;
    logic        unused_data_hi;

    assign fx = hcount_in >> SCALE_LOG2;
    assign fy = vcount_in >> SCALE_LOG2;

    assign in_range  = active_draw_in && (fx < 11'(FB_WIDTH)) && (fy < 10'(FB_HEIGHT));
    assign addr_next = fb_addr_of({5'b0, fx}, {6'b0, fy});

    assign cell_x0 = 11'({cell_q, 2'b00}) + 11'(cell_q);
    assign cursor  = CURSOR_EN && in_range
                     && (fx >= cell_x0) && (fx <= cell_x0 + 11'(CELL_WIDTH - 1))
                     && (fy >= 10'(STAFF_TOP)) && (fy < 10'(STAFF_TOP + STAFF_HEIGHT));

    assign last_hit = in_range && (addr_next == FB_LAST_ADDR);

    // Cell only moves at frame start so the cursor never tears mid-frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cell_q <= '0;
        end else if (new_frame_in) begin
            cell_q <= current_staff_cell_in;
        end
    end

    // The last pixel is read on four consecutive screen rows; report only the first.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fb_addr_out         <= '0;
            frame_read_done_out <= 1'b0;
            done_sticky_q       <= 1'b0;
        end else begin
            if (in_range) begin
                fb_addr_out <= addr_next;
            end
            frame_read_done_out <= last_hit && !done_sticky_q;
            done_sticky_q       <= new_frame_in ? 1'b0 : (done_sticky_q | last_hit);
        end
    end

    always_comb begin
        flags_in             = '0;
        flags_in.valid       = 1'b1;
        flags_in.in_range    = in_range;
        flags_in.cursor      = cursor;
        flags_in.hsync       = hsync_in;
        flags_in.vsync       = vsync_in;
        flags_in.active_draw = active_draw_in;
    end

    // Address register plus RAM latency; the colour register adds the last stage.
    pipeline_delay #(
        .WIDTH  ($bits(pix_flags_t)),
        .STAGES (READ_LATENCY + 1)
    ) u_flag_delay (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (flags_in),
        .q_out  (flags_dly)
    );

    assign pix_data       = fb_data_in[7:0];
    assign unused_data_hi = ^fb_data_in[15:8];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            red_out         <= '0;
            green_out       <= '0;
            blue_out        <= '0;
            hsync_out       <= 1'b0;
            vsync_out       <= 1'b0;
            active_draw_out <= 1'b0;
        end else begin
            hsync_out       <= flags_dly.hsync;
            vsync_out       <= flags_dly.vsync;
            active_draw_out <= flags_dly.active_draw;
            if (!flags_dly.valid) begin
                red_out   <= '0;
                green_out <= '0;
                blue_out  <= '0;
            end else if (!flags_dly.in_range) begin
                red_out   <= PIX_WHITE;
                green_out <= PIX_WHITE;
                blue_out  <= PIX_WHITE;
            end else begin
                red_out   <= pix_data;
                green_out <= pix_data;
                blue_out  <= flags_dly.cursor ? PIX_WHITE : pix_data;
            end
        end
    end

endmodule

// File: tb/tb_staff_frame_reader.sv
// Bench for staff_frame_reader: behavioural frame model plus a 2-cycle RAM model,
// directed boundary cases and randomized screen coordinates.
module tb_staff_frame_reader;

    localparam int D = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        active_draw_in = 1'b0;
    logic        new_frame_in = 1'b0;
    logic [5:0]  current_staff_cell_in = '0;
    logic [15:0] fb_data_in = '0;
    logic [15:0] fb_addr_out;
    logic [7:0]  red_out, green_out, blue_out;
    logic        hsync_out, vsync_out, active_draw_out, frame_read_done_out;

    staff_frame_reader #(
        .SCALE_LOG2   (2),
        .READ_LATENCY (2),
        .CURSOR_EN    (1'b1)
    ) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .hcount_in             (hcount_in),
        .vcount_in             (vcount_in),
        .hsync_in              (hsync_in),
        .vsync_in              (vsync_in),
        .active_draw_in        (active_draw_in),
        .new_frame_in          (new_frame_in),
        .current_staff_cell_in (current_staff_cell_in),
        .fb_data_in            (fb_data_in),
        .fb_addr_out           (fb_addr_out),
        .red_out               (red_out),
        .green_out             (green_out),
        .blue_out              (blue_out),
        .hsync_out             (hsync_out),
        .vsync_out             (vsync_out),
        .active_draw_out       (active_draw_out),
        .frame_read_done_out   (frame_read_done_out)
    );

    always #5 clk_in = ~clk_in;

    // RAM contents selected by fill_mode; upper byte is deliberately junk.
    int fill_mode = 1;

    function automatic logic [15:0] data_of(input logic [15:0] a);
        case (fill_mode)
            1:       return 16'hAB94;
            2:       return 16'h7E00;
            default: return {8'hC3 ^ a[7:0], a[7:0] ^ a[15:8] ^ 8'h5A};
        endcase
    endfunction

    logic [15:0] ram_rd1 = '0;
    always @(posedge clk_in) begin
        ram_rd1    <= data_of(fb_addr_out);
        fb_data_in <= ram_rd1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-pixel expected output from the screen rules.
    typedef struct packed {
        logic [7:0] r, g, b;
        logic hs, vs, act;
    } exp_t;

    exp_t        pipe [D];
    logic [15:0] m_addr;
    logic        m_done;
    logic        m_sticky;
    int          m_cell;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < D; i++) pipe[i] = '0;
            m_addr   = '0;
            m_done   = 1'b0;
            m_sticky = 1'b0;
            m_cell   = 0;
        end else begin
            int fx, fy, lin;
            bit inr, cur;
            exp_t e;
            logic [15:0] d;
            fx  = int'(hcount_in) / 4;
            fy  = int'(vcount_in) / 4;
            lin = fy * 320 + fx;
            inr = active_draw_in && fx < 320 && fy < 180;
            cur = inr && fx >= m_cell * 5 && fx <= m_cell * 5 + 4 && fy >= 75 && fy <= 109;
            e.hs  = hsync_in;
            e.vs  = vsync_in;
            e.act = active_draw_in;
            if (!inr) begin
                e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF;
            end else begin
                d   = data_of(16'(lin));
                e.r = d[7:0];
                e.g = d[7:0];
                e.b = cur ? 8'hFF : d[7:0];
            end
            for (int i = D - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = e;
            m_done = inr && lin == 57599 && !m_sticky;
            if (m_done) m_sticky = 1'b1;
            if (new_frame_in) m_sticky = 1'b0;
            if (inr) m_addr = 16'(lin);
            if (new_frame_in) m_cell = int'(current_staff_cell_in);
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            exp_t e;
            e = pipe[D-1];
            check("fb_addr", 32'(fb_addr_out), 32'(m_addr));
            check("frame_done", 32'(frame_read_done_out), 32'(m_done));
            check("pixel_rgb_sync",
                  32'({red_out, green_out, blue_out, hsync_out, vsync_out, active_draw_out}),
                  32'({e.r, e.g, e.b, e.hs, e.vs, e.act}));
        end
    end

    task automatic drive(input int hc, input int vc, input logic act,
                         input logic hs, input logic vs, input logic nf);
        hcount_in      = 11'(hc);
        vcount_in      = 10'(vc);
        active_draw_in = act;
        hsync_in       = hs;
        vsync_in       = vs;
        new_frame_in   = nf;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1300, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur_hc [8];
        int cur_vc [8];
        int cur_b  [5];
        int pulses;

        @(posedge clk_in);
        #1;
        chk_en = 1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // First pixels after reset: address latency 1, colour latency 4.
        drive(8, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        check("addr_first", 32'(fb_addr_out), 32'd322);
        drive(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("addr_origin", 32'(fb_addr_out), 32'd0);
        check("blank_after_release", 32'({red_out, active_draw_out}), 32'd0);
        idle(2);
        check("colour_first", 32'({red_out, green_out, blue_out}), 32'h949494);
        check("sync_first", 32'({hsync_out, vsync_out, active_draw_out}), 32'b101);
        idle(1);
        check("sync_second", 32'({hsync_out, vsync_out, active_draw_out}), 32'b011);

        // Blanking and fx=320 are white and leave the address alone.
        fill_mode = 2;
        drive(1300, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1280, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("addr_held", 32'(fb_addr_out), 32'd0);
        idle(2);
        check("blank_white", 32'({red_out, green_out, blue_out, active_draw_out}), 32'({24'hFFFFFF, 1'b0}));
        idle(1);
        check("fx320_white", 32'({red_out, green_out, blue_out, active_draw_out}), 32'({24'hFFFFFF, 1'b1}));

        // Last framebuffer pixel is in range.
        drive(1279, 719, 1'b1, 1'b0, 1'b0, 1'b0);
        check("addr_last", 32'(fb_addr_out), 32'd57599);
        idle(3);
        check("colour_last", 32'({red_out, green_out, blue_out}), 32'h000000);

        // Cursor on cell 10.
        fill_mode = 1;
        current_staff_cell_in = 6'd10;
        drive(1300, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(208, 320, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(220, 320, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("cursor_cell10", 32'({red_out, green_out, blue_out}), 32'h9494FF);
        idle(1);
        check("cursor_fx55", 32'({red_out, green_out, blue_out}), 32'h949494);

        // Cell change without a frame start must not move the cursor.
        current_staff_cell_in = 6'd20;
        drive(208, 320, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("cursor_no_tear", 32'(blue_out), 32'hFF);

        // Frame start coinciding with a cell change latches the new cell (63).
        current_staff_cell_in = 6'd63;
        drive(1300, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cur_hc = '{1260, 208, 1256, 1276, 1276, 1300, 1300, 1300};
        cur_vc = '{300, 320, 436, 439, 440, 0, 0, 0};
        cur_b  = '{'hFF, 'h94, 'h94, 'hFF, 'h94};
        for (int j = 0; j < 8; j++) begin
            drive(cur_hc[j], cur_vc[j], cur_hc[j] < 1280, 1'b0, 1'b0, 1'b0);
            if (j >= 3) check("cursor_cell63", 32'(blue_out), 32'(cur_b[j-3]));
        end

        // Done pulse: once per frame across the four repeated rows.
        for (int f = 0; f < 2; f++) begin
            drive(1300, 0, 1'b0, 1'b0, 1'b0, 1'b1);
            pulses = 0;
            for (int vc = 716; vc < 720; vc++) begin
                for (int hc = 1272; hc < 1284; hc++) begin
                    drive(hc, vc, hc < 1280, 1'b0, 1'b0, 1'b0);
                    if (frame_read_done_out) pulses++;
                end
            end
            check("done_once_per_frame", 32'(pulses), 32'd1);
            check("addr_after_rows", 32'(fb_addr_out), 32'd57599);
        end

        // Randomized screen positions, with a mid-line async reset halfway.
        idle(1);
        fill_mode = 0;
        for (int it = 0; it < 3000; it++) begin
            int hc, vc;
            logic act;
            if (it == 1500) begin
                @(posedge clk_in);
                #3;
                rst_in = 1'b1;
                #1;
                check("reset_colour_sync",
                      32'({red_out, green_out, blue_out, hsync_out, vsync_out, active_draw_out}), 32'd0);
                check("reset_addr_done", 32'({fb_addr_out, frame_read_done_out}), 32'd0);
                repeat (2) @(posedge clk_in);
                #1;
                rst_in = 1'b0;
                drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
                idle(2);
                check("blank_within_d", 32'({red_out, hsync_out, active_draw_out}), 32'd0);
                idle(1);
                check("resume_tracking", 32'({red_out, hsync_out, active_draw_out}), 32'({8'h5A, 2'b11}));
            end
            hc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1272, 1285)) : int'($urandom_range(0, 1649));
            vc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(712, 723)) : int'($urandom_range(0, 749));
            act = (hc < 1280 && vc < 720);
            if ($urandom_range(0, 7) == 0) act = ~act;
            if ($urandom_range(0, 7) == 0) current_staff_cell_in = 6'($urandom_range(0, 63));
            drive(hc, vc, act, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 63) == 0));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
